uart_rx: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 52 +++++
 rtl/uart_rx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, receiver FSM encoding and the
// fractional divider setting that produces the 16x sample tick.
package uart_pkg;

    // Frame shape, shared with uart_tx.
    localparam int DataBits = 8;
    localparam int StopBits = 1;

    // Receiver FSM states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // frac_div setting for a 16 x 9600 Hz tick from the 12 MHz ref_clk.
    localparam int FracDivWidth = 15;
    localparam int FracDivIncr  = 419;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for uart_rx: a two-flop synchroniser on the (optionally
// inverted) serial line, plus a 3-sample majority voter around mid-cell.
module uart_rx_sync #(
    parameter int Oversample = 16,
    parameter bit Invert     = 1'b0,
    parameter int CntW       = $clog2(Oversample)
) (
    input  logic            ref_clk,
    input  logic            rst_n,
    input  logic            sample_tick,
    input  logic            in,
    input  logic [CntW-1:0] cnt,
    output logic            line,
    output logic            vote
);

    localparam logic [CntW-1:0] SampA = CntW'(Oversample / 2 - 1);
    localparam logic [CntW-1:0] SampB = CntW'(Oversample / 2);

    logic sync_p0;
    logic sync_p1;
    logic samp_a;
    logic samp_b;

    // 2-of-3 decision on the two stored samples and the current one.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Stage p0/p1: resynchronise the line; resets to idle so reset never fakes a start bit.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= in ^ Invert;
            sync_p1 <= sync_p0;
        end
    end

    // Capture the two samples that precede the decision point of each cell.
    always_ff @(posedge ref_clk) begin
        if (sample_tick) begin
            if (cnt == SampA) samp_a <= sync_p1;
            if (cnt == SampB) samp_b <= sync_p1;
        end
    end

    assign line = sync_p1;
    assign vote = maj3(samp_a, samp_b, sync_p1);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampling on an Oversample x baud tick.
// The tick comes from a frac_div at board level (FracDivWidth/FracDivIncr in
// uart_pkg give 16 x 9600 at 12 MHz). Received bytes land in a one-entry
// holding register read through a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int Oversample = 16,
    parameter bit Invert     = 1'b0
) (
    input  logic       ref_clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       in,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int              CntW    = $clog2(Oversample);
    localparam logic [CntW-1:0] CntLast = CntW'(Oversample - 1);
    localparam logic [CntW-1:0] DecPt   = CntW'(Oversample / 2 + 1);

    logic [2:0]          state;
    logic [CntW-1:0]     cnt;
    logic [CntW-1:0]     cnt_nxt;
    logic [2:0]          bit_idx;
    logic [DataBits-1:0] sr;
    logic                line;
    logic                vote;
    logic                stop_dec;
    logic                deliver;
    logic                stop_bad;

    uart_rx_sync #(
        .Oversample(Oversample),
        .Invert    (Invert),
        .CntW      (CntW)
    ) u_sync (
        .ref_clk    (ref_clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .in         (in),
        .cnt        (cnt),
        .line       (line),
        .vote       (vote)
    );

    assign cnt_nxt  = (cnt == CntLast) ? '0 : cnt + 1'b1;
    assign stop_dec = sample_tick && (state == ST_STOP) && (cnt == DecPt);
    assign deliver  = stop_dec && vote;
    assign stop_bad = stop_dec && !vote;
    assign busy     = (state != ST_IDLE);

    // Frame sequencing: bit-cell counter, bit index and state, all tick-paced.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else if (sample_tick) begin
            cnt <= cnt_nxt;
            case (state)
                ST_IDLE: begin
                    // Hold the counter while idle; the start edge restarts it at 1.
                    cnt <= cnt;
                    if (!line) begin
                        cnt   <= CntW'(1);
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == DecPt && vote) begin
                        state <= ST_IDLE;
                    end else if (cnt == CntLast) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (cnt == CntLast) begin
                        if (bit_idx == 3'(DataBits - 1)) state <= ST_STOP;
                        else                             bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-cell so a start edge right after the stop bit is caught.
                    if (cnt == DecPt) state <= vote ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    if (line) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift each voted data bit in at the MSB so the LSB-first byte lines up.
    always_ff @(posedge ref_clk) begin
        if (sample_tick && state == ST_DATA && cnt == DecPt) begin
            sr <= {vote, sr[DataBits-1:1]};
        end
    end

    // Holding register and status pulses; a full register drops the new byte.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                dout  <= sr;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
